// File: rtl/lcd16x2_monitor.sv
// lcd16x2_monitor
//   Passive HD44780-style receiver for the 16x2 LCD pins. It keeps a 32-byte
//   shadow of the display (index 0-15 = line 1, 16-31 = line 2), decodes the
//   command subset issued by our LCD controller, and tracks the cursor.
//
// Ports
//   clk_i       : single clock, rising edge
//   rst_i       : asynchronous active-high reset; an auto-clear follows release
//   lcd_rs_i    : register select (0 = command, 1 = data)
//   lcd_e_i     : enable strobe; a transaction is taken on its falling edge
//   lcd_data_i  : bus byte
//   rd_addr_i   : shadow read index
//   rd_data_o   : shadow byte at rd_addr_i, one cycle later
//   cursor_o    : current write index
//   wr_stb_o    : one-cycle pulse per accepted data write
//   cmd_stb_o   : one-cycle pulse per accepted command
//   cmd_o       : last accepted command byte
//   busy_o      : high while the shadow is being cleared
//   err_o       : sticky error (bad DDRAM address or transaction while busy)
module lcd16x2_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       lcd_rs_i,
    input  logic       lcd_e_i,
    input  logic [7:0] lcd_data_i,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic [4:0] cursor_o,
    output logic       wr_stb_o,
    output logic       cmd_stb_o,
    output logic [7:0] cmd_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Synchronizer chain; each stage carries {E, RS, data} so the three
    // stay aligned and the transaction fields match the detected fall.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [9:0] stage_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) stage_reg <= '0;
                else       stage_reg <= {lcd_e_i, lcd_rs_i, lcd_data_i};
            end
        end else begin : g_rest
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) stage_reg <= '0;
                else       stage_reg <= g_sync[gi-1].stage_reg;
            end
        end
    end

    logic [9:0] sync_last;
    logic       e_sync;
    logic       rs_sync;
    logic [7:0] data_sync;
    logic       e_dly_reg;
    logic       fall;

    assign sync_last = g_sync[SYNC_STAGES-1].stage_reg;
    assign e_sync    = sync_last[9];
    assign rs_sync   = sync_last[8];
    assign data_sync = sync_last[7:0];
    assign fall      = ~e_sync & e_dly_reg;

    state_t     state_reg, state_next;
    logic [4:0] clr_idx_reg, clr_idx_next;
    logic [4:0] cursor_reg, cursor_next;
    logic       inc_reg, inc_next;
    logic       wr_stb_reg, wr_stb_next;
    logic       cmd_stb_reg, cmd_stb_next;
    logic [7:0] cmd_reg, cmd_next;
    logic       err_reg, err_next;

    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [7:0] shadow_mem [32];
    logic [7:0] rd_data_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e_dly_reg   <= 1'b0;
            state_reg   <= ST_CLEAR;   // reset itself launches the auto-clear
            clr_idx_reg <= 5'd0;
            cursor_reg  <= 5'd0;
            inc_reg     <= 1'b1;
            wr_stb_reg  <= 1'b0;
            cmd_stb_reg <= 1'b0;
            cmd_reg     <= 8'h00;
            err_reg     <= 1'b0;
        end else begin
            e_dly_reg   <= e_sync;
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
            cursor_reg  <= cursor_next;
            inc_reg     <= inc_next;
            wr_stb_reg  <= wr_stb_next;
            cmd_stb_reg <= cmd_stb_next;
            cmd_reg     <= cmd_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        cursor_next  = cursor_reg;
        inc_next     = inc_reg;
        wr_stb_next  = 1'b0;
        cmd_stb_next = 1'b0;
        cmd_next     = cmd_reg;
        err_next     = err_reg;
        mem_we       = 1'b0;
        mem_waddr    = cursor_reg;
        mem_wdata    = data_sync;

        case (state_reg)
            ST_CLEAR: begin
                // One blank per cycle, ascending; anything on the bus is dropped.
                mem_we       = 1'b1;
                mem_waddr    = clr_idx_reg;
                mem_wdata    = 8'h20;
                clr_idx_next = clr_idx_reg + 5'd1;
                if (clr_idx_reg == 5'd31) state_next = ST_RUN;
                if (fall) err_next = 1'b1;
            end
            default: begin
                if (fall) begin
                    if (rs_sync) begin
                        mem_we      = 1'b1;
                        wr_stb_next = 1'b1;
                        cursor_next = inc_reg ? cursor_reg + 5'd1 : cursor_reg - 5'd1;
                    end else if (data_sync[7]) begin
                        // Only the first 16 columns of each line are mapped.
                        if (data_sync[6:4] == 3'b000 || data_sync[6:4] == 3'b100) begin
                            cursor_next  = {data_sync[6], data_sync[3:0]};
                            cmd_stb_next = 1'b1;
                            cmd_next     = data_sync;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        cmd_stb_next = 1'b1;
                        cmd_next     = data_sync;
                        if (data_sync[6:3] != 4'd0) begin
                            // display control / shift / function set / CGRAM: no effect
                        end else if (data_sync[2]) begin
                            inc_next = data_sync[1];
                        end else if (data_sync[1]) begin
                            cursor_next = 5'd0;
                        end else if (data_sync[0]) begin
                            cursor_next  = 5'd0;
                            inc_next     = 1'b1;
                            state_next   = ST_CLEAR;
                            clr_idx_next = 5'd0;
                        end
                    end
                end
            end
        endcase
    end

    // Shadow RAM: write port carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) shadow_mem[mem_waddr] <= mem_wdata;
    end

    // Registered read; a same-cycle write to the same index returns old data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_data_reg <= 8'h00;
        else       rd_data_reg <= shadow_mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_reg;
    assign cursor_o  = cursor_reg;
    assign wr_stb_o  = wr_stb_reg;
    assign cmd_stb_o = cmd_stb_reg;
    assign cmd_o     = cmd_reg;
    assign busy_o    = (state_reg == ST_CLEAR);
    assign err_o     = err_reg;

endmodule

// File: tb/tb_lcd16x2_monitor.sv
// Directed testbench for lcd16x2_monitor.
module tb_lcd16x2_monitor;

    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic       lcd_rs;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cursor;
    logic       wr_stb;
    logic       cmd_stb;
    logic [7:0] cmd;
    logic       busy;
    logic       err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wr_cnt    = 0;
    int cmd_cnt   = 0;
    int both_cnt  = 0;

    lcd16x2_monitor #(.SYNC_STAGES(SYNC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .lcd_rs_i   (lcd_rs),
        .lcd_e_i    (lcd_e),
        .lcd_data_i (lcd_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .cursor_o   (cursor),
        .wr_stb_o   (wr_stb),
        .cmd_stb_o  (cmd_stb),
        .cmd_o      (cmd),
        .busy_o     (busy),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb)           wr_cnt++;
        if (cmd_stb)          cmd_cnt++;
        if (wr_stb && cmd_stb) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic xfer(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_data = d; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (5) @(negedge clk);
        $display("xfer rs=%0d data=0x%02h cursor=%0d busy=%0d err=%0d", rs, d, cursor, busy, err);
    endtask

    task automatic read_byte(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    // Counts samples with busy high, starting with the current one.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        int n;
        int bad;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL reset_busy: got %0b want 1", busy); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd0) $display("FAIL reset_cursor: got %0d want 0", cursor); else pass_cnt++;
        total_cnt++; if (cmd !== 8'h00) $display("FAIL reset_cmd: got 0x%02h want 0x00", cmd); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got 0x%02h want 0x00", rd_data); else pass_cnt++;
        total_cnt++; if ({wr_stb, cmd_stb, err} !== 3'b000) $display("FAIL reset_flags: got %03b want 000", {wr_stb, cmd_stb, err}); else pass_cnt++;
        rst = 1'b0;
        count_busy(n);
        total_cnt++; if (n !== 32) $display("FAIL auto_clear_len: got %0d want 32", n); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            read_byte(5'(i), d);
            if (d !== 8'h20) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL auto_clear_fill: got %0d non-blank want 0", bad); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd0 || err !== 1'b0) $display("FAIL after_clear: got cursor=%0d err=%0b want 0/0", cursor, err); else pass_cnt++;
        $display("reset: busy cycles=%0d", n);
    endtask

    task automatic test_hello;
        logic [7:0] msg [5];
        logic [7:0] d;
        int w0, c0, lat;
        msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C; msg[4] = 8'h4F;
        w0 = wr_cnt; c0 = cmd_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            lcd_rs = 1'b1; lcd_data = msg[i]; lcd_e = 1'b1;
            repeat (4) @(negedge clk);
            lcd_e = 1'b0;
            lat = -1;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                if (wr_stb && lat < 0) lat = j;
            end
            $display("write 0x%02h strobe latency=%0d", msg[i], lat);
            total_cnt++; if (lat !== SYNC) $display("FAIL hello_latency[%0d]: got %0d want %0d", i, lat, SYNC); else pass_cnt++;
        end
        total_cnt++; if (wr_cnt - w0 !== 5) $display("FAIL hello_wr_count: got %0d want 5", wr_cnt - w0); else pass_cnt++;
        total_cnt++; if (cmd_cnt - c0 !== 0) $display("FAIL hello_cmd_count: got %0d want 0", cmd_cnt - c0); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd5) $display("FAIL hello_cursor: got %0d want 5", cursor); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            read_byte(5'(i), d);
            total_cnt++; if (d !== msg[i]) $display("FAIL hello_byte[%0d]: got 0x%02h want 0x%02h", i, d, msg[i]); else pass_cnt++;
        end
    endtask

    task automatic test_line2;
        logic [7:0] d;
        int c0;
        c0 = cmd_cnt;
        xfer(1'b0, 8'hC0);
        total_cnt++; if (cmd !== 8'hC0) $display("FAIL line2_cmd: got 0x%02h want 0xC0", cmd); else pass_cnt++;
        total_cnt++; if (cmd_cnt - c0 !== 1) $display("FAIL line2_cmd_stb: got %0d want 1", cmd_cnt - c0); else pass_cnt++;
        xfer(1'b1, 8'h57);
        read_byte(5'd16, d);
        total_cnt++; if (d !== 8'h57) $display("FAIL line2_byte: got 0x%02h want 0x57", d); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd17) $display("FAIL line2_cursor: got %0d want 17", cursor); else pass_cnt++;
    endtask

    task automatic test_decrement;
        logic [7:0] d;
        xfer(1'b0, 8'h04);
        xfer(1'b0, 8'h80);
        xfer(1'b1, 8'h41);
        read_byte(5'd0, d);
        total_cnt++; if (d !== 8'h41) $display("FAIL dec_byte0: got 0x%02h want 0x41", d); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd31) $display("FAIL dec_wrap: got %0d want 31", cursor); else pass_cnt++;
        xfer(1'b1, 8'h42);
        read_byte(5'd31, d);
        total_cnt++; if (d !== 8'h42) $display("FAIL dec_byte31: got 0x%02h want 0x42", d); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd30) $display("FAIL dec_cursor: got %0d want 30", cursor); else pass_cnt++;
    endtask

    task automatic test_bad_addr;
        int c0;
        total_cnt++; if (err !== 1'b0) $display("FAIL err_before: got %0b want 0", err); else pass_cnt++;
        c0 = cmd_cnt;
        xfer(1'b0, 8'h90);
        total_cnt++; if (err !== 1'b1) $display("FAIL bad_addr_err: got %0b want 1", err); else pass_cnt++;
        total_cnt++; if (cmd_cnt - c0 !== 0) $display("FAIL bad_addr_stb: got %0d want 0", cmd_cnt - c0); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd30) $display("FAIL bad_addr_cursor: got %0d want 30", cursor); else pass_cnt++;
        total_cnt++; if (cmd !== 8'h80) $display("FAIL bad_addr_cmd: got 0x%02h want 0x80", cmd); else pass_cnt++;
    endtask

    task automatic test_clear_timing;
        int n;
        @(negedge clk);
        lcd_rs = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        n = 0;
        while (!cmd_stb && n < 10) begin
            @(negedge clk);
            n++;
        end
        total_cnt++; if (cmd_stb !== 1'b1) $display("FAIL clear_stb: got %0b want 1", cmd_stb); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL clear_busy_start: got %0b want 1", busy); else pass_cnt++;
        count_busy(n);
        $display("clear: busy cycles=%0d", n);
        total_cnt++; if (n !== 32) $display("FAIL clear_len: got %0d want 32", n); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd0) $display("FAIL clear_cursor: got %0d want 0", cursor); else pass_cnt++;
    endtask

    task automatic test_busy_drop;
        logic [7:0] d;
        int w0, n;
        xfer(1'b0, 8'h01);
        w0 = wr_cnt;
        xfer(1'b1, 8'h58);
        total_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL drop_wr_stb: got %0d want 0", wr_cnt - w0); else pass_cnt++;
        count_busy(n);
        total_cnt++; if (busy !== 1'b0) $display("FAIL drop_busy_end: got %0b want 0", busy); else pass_cnt++;
        read_byte(5'd0, d);
        total_cnt++; if (d !== 8'h20) $display("FAIL drop_byte0: got 0x%02h want 0x20", d); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL drop_err: got %0b want 1", err); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd0) $display("FAIL drop_cursor: got %0d want 0", cursor); else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear;
        logic [7:0] d;
        int n;
        xfer(1'b0, 8'h01);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %0b want 1", busy); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL midrst_err: got %0b want 0", err); else pass_cnt++;
        total_cnt++; if (cmd !== 8'h00) $display("FAIL midrst_cmd: got 0x%02h want 0x00", cmd); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        $display("reset mid-clear: busy cycles=%0d", n);
        total_cnt++; if (n !== 32) $display("FAIL midrst_len: got %0d want 32", n); else pass_cnt++;
        read_byte(5'd16, d);
        total_cnt++; if (d !== 8'h20) $display("FAIL midrst_byte16: got 0x%02h want 0x20", d); else pass_cnt++;
    endtask

    task automatic test_e_high_reset;
        logic [7:0] d;
        int w0, n;
        w0 = wr_cnt;
        @(negedge clk);
        lcd_rs = 1'b1; lcd_data = 8'h33; lcd_e = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        repeat (6) @(negedge clk);
        total_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL ehigh_no_stb: got %0d want 0", wr_cnt - w0); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL ehigh_err: got %0b want 0", err); else pass_cnt++;
        lcd_e = 1'b0;
        repeat (5) @(negedge clk);
        total_cnt++; if (wr_cnt - w0 !== 1) $display("FAIL ehigh_stb: got %0d want 1", wr_cnt - w0); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd1) $display("FAIL ehigh_cursor: got %0d want 1", cursor); else pass_cnt++;
        read_byte(5'd0, d);
        total_cnt++; if (d !== 8'h33) $display("FAIL ehigh_byte0: got 0x%02h want 0x33", d); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int w0, c0;
        w0 = wr_cnt; c0 = cmd_cnt;
        xfer(1'b0, 8'h06);
        xfer(1'b1, 8'h61);
        xfer(1'b0, 8'h0C);
        xfer(1'b1, 8'h62);
        total_cnt++; if (wr_cnt - w0 !== 2) $display("FAIL b2b_wr: got %0d want 2", wr_cnt - w0); else pass_cnt++;
        total_cnt++; if (cmd_cnt - c0 !== 2) $display("FAIL b2b_cmd: got %0d want 2", cmd_cnt - c0); else pass_cnt++;
        total_cnt++; if (cursor !== 5'd3) $display("FAIL b2b_cursor: got %0d want 3", cursor); else pass_cnt++;
        total_cnt++; if (both_cnt !== 0) $display("FAIL strobe_overlap: got %0d want 0", both_cnt); else pass_cnt++;
    endtask

    initial begin
        rst      = 1'b1;
        lcd_rs   = 1'b0;
        lcd_e    = 1'b0;
        lcd_data = 8'h00;
        rd_addr  = 5'd0;
        test_reset;
        test_hello;
        test_line2;
        test_decrement;
        test_bad_addr;
        test_clear_timing;
        test_busy_drop;
        test_reset_mid_clear;
        test_e_high_reset;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
